// File: rtl/sha1_result_collector.sv
// sha1_result_collector
// Collects matching nonces from the nonce-search stage into a small FIFO,
// hands them to the host over valid/ready, counts hashes and matches, and
// reports completion once the search is done and every result has drained.
// Optional feature macro: SHA1_COLLECT_CONTEXT_EN (store the 160-bit digest
// alongside each nonce; otherwise res_context is tied to zero).
module sha1_result_collector #(
  parameter int NONCE_SIZE = 16,
  parameter int DEPTH      = 4,
  parameter int COUNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  hash_in,
  input  logic                  match_in,
  input  logic                  done_in,
  input  logic [NONCE_SIZE-1:0] nonce_in,
  input  logic [159:0]          context_in,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [NONCE_SIZE-1:0] res_nonce,
  output logic [159:0]          res_context,
  output logic [COUNT_W-1:0]    hash_count,
  output logic [COUNT_W-1:0]    match_count,
  output logic                  overflow,
  output logic                  busy,
  output logic                  complete
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, COMPLETE} state_t;

  state_t                  state_q;
  logic [AW:0]             wp_q, wp_d, rp_q, rp_d;
  logic [COUNT_W-1:0]      hashCount_q, hashCount_d;
  logic [COUNT_W-1:0]      matchCount_q, matchCount_d;
  logic                    overflow_q, overflow_d;
  logic [NONCE_SIZE-1:0]   nonceMem_q [DEPTH];

  logic empty, full, pop, capture, hit, push, drop, emptyNext;

  // The extra pointer bit distinguishes a full FIFO from an empty one
  assign empty     = (wp_q == rp_q);
  assign full      = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop       = !empty && res_ready;
  assign capture   = (state_q == RUN) && !start;
  assign hit       = capture && hash_in && match_in;
  assign push      = hit && (!full || pop);
  assign drop      = hit && full && !pop;
  assign emptyNext = (wp_d == rp_d);

  // Next-state for pointers, counters and the sticky overflow flag; start flushes everything
  always_comb begin
    wp_d         = wp_q;
    rp_d         = rp_q;
    hashCount_d  = hashCount_q;
    matchCount_d = matchCount_q;
    overflow_d   = overflow_q;
    if (start) begin
      wp_d         = '0;
      rp_d         = '0;
      hashCount_d  = '0;
      matchCount_d = '0;
      overflow_d   = 1'b0;
    end else begin
      if (pop)  rp_d = rp_q + 1'b1;
      if (push) wp_d = wp_q + 1'b1;
      if (capture && hash_in && (hashCount_q != {COUNT_W{1'b1}}))
        hashCount_d = hashCount_q + 1'b1;
      if (hit && (matchCount_q != {COUNT_W{1'b1}}))
        matchCount_d = matchCount_q + 1'b1;
      if (drop) overflow_d = 1'b1;
    end
  end

  // Register pointers, counters, overflow and the search FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wp_q         <= '0;
      rp_q         <= '0;
      hashCount_q  <= '0;
      matchCount_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      hashCount_q  <= hashCount_d;
      matchCount_q <= matchCount_d;
      overflow_q   <= overflow_d;
      if (start) begin
        state_q <= RUN;
      end else begin
        case (state_q)
          IDLE:     state_q <= IDLE;
          RUN:      if (done_in) state_q <= emptyNext ? COMPLETE : DRAIN;
          DRAIN:    if (emptyNext) state_q <= COMPLETE;
          COMPLETE: state_q <= COMPLETE;
          default:  state_q <= IDLE;
        endcase
      end
    end
  end

  // FIFO storage needs no reset: outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) nonceMem_q[wp_q[AW-1:0]] <= nonce_in;
  end

  assign res_valid   = !empty;
  assign res_nonce   = empty ? '0 : nonceMem_q[rp_q[AW-1:0]];
  assign hash_count  = hashCount_q;
  assign match_count = matchCount_q;
  assign overflow    = overflow_q;
  assign busy        = (state_q == RUN) || (state_q == DRAIN);
  assign complete    = (state_q == COMPLETE);

`ifdef SHA1_COLLECT_CONTEXT_EN
  logic [159:0] ctxMem_q [DEPTH];

  // Digest storage travels in lockstep with the nonce storage
  always_ff @(posedge clk) begin
    if (push) ctxMem_q[wp_q[AW-1:0]] <= context_in;
  end

  assign res_context = empty ? '0 : ctxMem_q[rp_q[AW-1:0]];
`else
  logic unusedContext;
  assign unusedContext = ^context_in;
  assign res_context   = '0;
`endif

endmodule

// File: tb/tb_sha1_result_collector.sv
// Testbench for sha1_result_collector: directed steps driven against a
// scoreboard queue of expected results, plus constant checks at key points.
module tb_sha1_result_collector;

  localparam int DEPTH = 4;

  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_COMPLETE = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, hash_in = 1'b0, match_in = 1'b0, done_in = 1'b0;
  logic [15:0]   nonce_in = '0;
  logic [159:0]  context_in = '0;
  logic          res_valid, res_ready = 1'b0;
  logic [15:0]   res_nonce;
  logic [159:0]  res_context;
  logic [31:0]   hash_count, match_count;
  logic          overflow, busy, complete;

  typedef struct {
    logic [15:0]  nonce;
    logic [159:0] ctx;
  } entry_t;

  entry_t sb[$];
  int     mState = S_IDLE;
  int     mHash = 0, mMatch = 0;
  logic   mOvf = 1'b0;
  int     checkCount = 0;
  int     errorCount = 0;

  sha1_result_collector #(.NONCE_SIZE(16), .DEPTH(DEPTH), .COUNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hash_in(hash_in),
    .match_in(match_in), .done_in(done_in), .nonce_in(nonce_in),
    .context_in(context_in), .res_valid(res_valid), .res_ready(res_ready),
    .res_nonce(res_nonce), .res_context(res_context), .hash_count(hash_count),
    .match_count(match_count), .overflow(overflow), .busy(busy),
    .complete(complete)
  );

  always #5 clk = ~clk;

  function automatic logic [159:0] ctxFor(input logic [15:0] n);
    logic [127:0] salt;
    salt = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    return {n, ~n, salt};
  endfunction

  function automatic logic [159:0] expCtx(input logic [159:0] c);
`ifdef SHA1_COLLECT_CONTEXT_EN
    return c;
`else
    return (c & 160'h0);
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [159:0] observed,
                             input logic [159:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Compare every output with the scoreboard, then advance the model
  task automatic modelStep();
    logic mPop, mFull;
    entry_t e;
    checkOutput("res_valid", res_valid, (sb.size() != 0));
    checkOutput("res_nonce", res_nonce, (sb.size() != 0) ? sb[0].nonce : 16'h0);
    checkOutput("res_context", res_context, (sb.size() != 0) ? expCtx(sb[0].ctx) : 160'h0);
    checkOutput("hash_count", hash_count, mHash);
    checkOutput("match_count", match_count, mMatch);
    checkOutput("overflow", overflow, mOvf);
    checkOutput("busy", busy, (mState == S_RUN) || (mState == S_DRAIN));
    checkOutput("complete", complete, (mState == S_COMPLETE));
    mPop  = (sb.size() != 0) && res_ready;
    mFull = (sb.size() == DEPTH);
    if (start) begin
      sb.delete();
      mHash = 0; mMatch = 0; mOvf = 1'b0; mState = S_RUN;
    end else begin
      if (mPop) void'(sb.pop_front());
      if (mState == S_RUN && hash_in) begin
        mHash++;
        if (match_in) begin
          mMatch++;
          if (!mFull || mPop) begin
            e.nonce = nonce_in;
            e.ctx   = context_in;
            sb.push_back(e);
          end else begin
            mOvf = 1'b1;
          end
        end
      end
      if (mState == S_RUN && done_in)
        mState = (sb.size() == 0) ? S_COMPLETE : S_DRAIN;
      else if (mState == S_DRAIN && sb.size() == 0)
        mState = S_COMPLETE;
    end
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance past the rising edge
  task automatic applyStimulus(input logic st, input logic hs, input logic mt,
                               input logic dn, input logic [15:0] nc,
                               input logic rdy);
    start = st; hash_in = hs; match_in = mt; done_in = dn;
    nonce_in = nc; context_in = ctxFor(nc); res_ready = rdy;
    @(negedge clk);
    modelStep();
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] sha1_result_collector bench starting");
    #1;
    checkOutput("reset_valid", res_valid, 1'b0);
    checkOutput("reset_hash", hash_count, 32'd0);
    checkOutput("reset_busy", busy, 1'b0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: ten hashes, matches on nonces 3 and 7, consumer always ready
    applyStimulus(1, 0, 0, 0, 16'd0, 1);
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 1, (i == 3 || i == 7), 0, 16'(i), 1);
    applyStimulus(0, 0, 0, 0, 16'd0, 1);
    checkOutput("t1_hash_count", hash_count, 32'd10);
    checkOutput("t1_match_count", match_count, 32'd2);

    // Test 2: five matches into a four-entry FIFO with the consumer stalled
    applyStimulus(1, 0, 0, 0, 16'd0, 0);
    for (int i = 1; i <= 5; i++)
      applyStimulus(0, 1, 1, 0, 16'(i), 0);
    checkOutput("t2_overflow", overflow, 1'b1);
    checkOutput("t2_match_count", match_count, 32'd5);
    checkOutput("t2_head", res_nonce, 16'd1);
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 0, 0, 0, 16'd0, 1);
    checkOutput("t2_drained", res_valid, 1'b0);

    // Test 3: match arrives on the same cycle a full FIFO pops
    applyStimulus(1, 0, 0, 0, 16'd0, 0);
    for (int i = 1; i <= 4; i++)
      applyStimulus(0, 1, 1, 0, 16'(i), 0);
    applyStimulus(0, 1, 1, 0, 16'd9, 1);
    checkOutput("t3_overflow", overflow, 1'b0);
    checkOutput("t3_head", res_nonce, 16'd2);
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 0, 0, 0, 16'd0, 1);

    // Test 4: done with two entries queued drains first; done on empty completes at once
    applyStimulus(1, 0, 0, 0, 16'd0, 0);
    applyStimulus(0, 1, 1, 0, 16'd21, 0);
    applyStimulus(0, 1, 1, 0, 16'd22, 0);
    applyStimulus(0, 0, 0, 1, 16'd0, 0);
    checkOutput("t4_busy_drain", busy, 1'b1);
    checkOutput("t4_not_complete", complete, 1'b0);
    applyStimulus(0, 0, 0, 1, 16'd0, 1);
    applyStimulus(0, 0, 0, 1, 16'd0, 1);
    checkOutput("t4_complete", complete, 1'b1);
    checkOutput("t4_idle_busy", busy, 1'b0);
    applyStimulus(1, 0, 0, 0, 16'd0, 1);
    applyStimulus(0, 0, 0, 1, 16'd0, 1);
    checkOutput("t4_empty_complete", complete, 1'b1);

    // Test 5: start during DRAIN with a match on the start cycle
    applyStimulus(1, 0, 0, 0, 16'd0, 0);
    for (int i = 1; i <= 5; i++)
      applyStimulus(0, 1, 1, 0, 16'(30 + i), 0);
    applyStimulus(0, 0, 0, 1, 16'd0, 0);
    checkOutput("t5_in_drain", busy, 1'b1);
    applyStimulus(1, 1, 1, 0, 16'h55, 0);
    checkOutput("t5_valid", res_valid, 1'b0);
    checkOutput("t5_hash", hash_count, 32'd0);
    checkOutput("t5_match", match_count, 32'd0);
    checkOutput("t5_overflow", overflow, 1'b0);
    checkOutput("t5_busy", busy, 1'b1);

    // Test 6: asynchronous reset in the middle of a run
    applyStimulus(0, 1, 1, 0, 16'd41, 0);
    applyStimulus(0, 1, 1, 0, 16'd42, 0);
    checkOutput("t6_ctx_before", res_context, expCtx(ctxFor(16'd41)));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_valid", res_valid, 1'b0);
    checkOutput("t6_nonce", res_nonce, 16'd0);
    checkOutput("t6_context", res_context, 160'h0);
    checkOutput("t6_hash", hash_count, 32'd0);
    checkOutput("t6_match", match_count, 32'd0);
    checkOutput("t6_busy", busy, 1'b0);
    checkOutput("t6_complete", complete, 1'b0);
    sb.delete();
    mHash = 0; mMatch = 0; mOvf = 1'b0; mState = S_IDLE;
    #1 rst_n = 1'b1;
    applyStimulus(0, 1, 1, 0, 16'd50, 1);
    applyStimulus(1, 0, 0, 0, 16'd0, 1);
    applyStimulus(0, 1, 1, 0, 16'd51, 1);
    applyStimulus(0, 0, 0, 1, 16'd0, 1);
    applyStimulus(0, 0, 0, 0, 16'd0, 1);
    checkOutput("t6_restart_hash", hash_count, 32'd1);
    checkOutput("t6_restart_complete", complete, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
